code_serializer: RTL and testbench

//  Downstream consumer of the 7-to-3 encoder output. Accepts a CODE_W-bit code

---
 rtl/code_serializer.sv | 115 +++++++++++
 tb/tb_code_serializer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/code_serializer.sv
// Serializes a CODE_W-bit code onto one wire, LSB first: start(0), data, even parity, stop(1).
// A one-entry holding register lets the next code be accepted while a frame is in flight.
module code_serializer #(
  parameter int CODE_W = 3,
  parameter int DIV    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [CODE_W-1:0] in_code,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);
  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(DIV - 1);
  localparam logic [TW-1:0] T_PRE  = TW'((DIV > 1) ? DIV - 2 : 0);
  localparam logic [BW-1:0] B_LAST = BW'(CODE_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state;
  logic [TW-1:0]     timer;
  logic [BW-1:0]     bit_idx;
  logic [CODE_W-1:0] hold;
  logic [CODE_W-1:0] shift;
  logic [CODE_W-1:0] shift_nxt;
  logic              hold_valid;
  logic              parity;
  logic              take;
  logic              load;
  logic              wrap;

  // Handshake: a transfer happens on a rising edge where in_valid & in_ready;
  // in_ready is purely registered (empty holding register), never a function of in_valid.
  assign in_ready  = !hold_valid;
  assign take      = in_valid && !hold_valid;
  assign wrap      = (timer == T_LAST);
  assign load      = hold_valid && ((state == IDLE) || ((state == STOP) && wrap));
  assign shift_nxt = shift >> 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold       <= '0;
    end else if (take) begin
      hold_valid <= 1'b1;
      hold       <= in_code;
    end else if (load) begin
      hold_valid <= 1'b0;
    end
  end

  // tx/busy/done are registered alongside the state so they change only on edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
      parity  <= 1'b0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        state   <= START;
        timer   <= '0;
        bit_idx <= '0;
        shift   <= hold;
        parity  <= ^hold;
        tx      <= 1'b0;
        busy    <= 1'b1;
      end else if (state != IDLE) begin
        if (!wrap) begin
          timer <= timer + 1'b1;
          done  <= (state == STOP) && (timer == T_PRE);
        end else begin
          timer <= '0;
          case (state)
            START: begin
              state   <= DATA;
              bit_idx <= '0;
              tx      <= shift[0];
            end
            DATA: begin
              if (bit_idx == B_LAST) begin
                state <= PARITY;
                tx    <= parity;
              end else begin
                bit_idx <= bit_idx + 1'b1;
                shift   <= shift_nxt;
                tx      <= shift_nxt[0];
              end
            end
            PARITY: begin
              state <= STOP;
              tx    <= 1'b1;
              done  <= (DIV == 1);
            end
            default: begin
              // End of STOP with nothing held (a held code is handled by load).
              state <= IDLE;
              tx    <= 1'b1;
              busy  <= 1'b0;
            end
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_code_serializer.sv
// Bench for code_serializer: DIV=4 instance with a line monitor and scoreboard, plus a DIV=1 instance.
module tb_code_serializer;
  localparam int W = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic [W-1:0] in_code = '0;
  logic         in_ready, tx, busy, done;
  logic         v1 = 1'b0;
  logic [W-1:0] c1 = '0;
  logic         r1, tx1, b1, d1;

  code_serializer #(.CODE_W(W), .DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_code(in_code),
    .in_ready(in_ready), .tx(tx), .busy(busy), .done(done)
  );

  code_serializer #(.CODE_W(W), .DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_code(c1),
    .in_ready(r1), .tx(tx1), .busy(b1), .done(d1)
  );

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  int rx_frames = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line monitor for the DIV=4 instance: decodes frames at mid-bit and checks done timing.
  logic       rx_act = 1'b0;
  int         rx_cnt = 0;
  logic [5:0] rx_bits = '0;
  logic [W-1:0] rx_code;
  always @(negedge clk) begin
    if (!rst_n) begin
      rx_act = 1'b0;
    end else begin
      if (!rx_act && tx === 1'b0) begin
        rx_act = 1'b1;
        rx_cnt = 0;
      end
      chk("mon_done", done, rx_act && rx_cnt == 23);
      if (rx_act) begin
        if (rx_cnt % 4 == 2) rx_bits[rx_cnt / 4] = tx;
        if (rx_cnt == 23) begin
          rx_act = 1'b0;
          rx_frames++;
          rx_code = rx_bits[3:1];
          chk("mon_framing", {rx_bits[0], rx_bits[5], rx_bits[4]}, {1'b0, 1'b1, ^rx_code});
          if (exp_q.size() == 0) chk("mon_unexpected_frame", exp_q.size(), 1);
          else chk("mon_code", rx_code, exp_q.pop_front());
        end else begin
          rx_cnt++;
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] code, output int waited);
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_code  = code;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("send_ready", in_ready, 1);
    @(posedge clk);
    if (in_ready) exp_q.push_back(code);
    #1 in_valid = 1'b0;
  endtask

  // c counts cycles from the first START cycle; fb holds up to two frames, frame bit j at fb[j].
  task automatic watch(input string name, input logic [11:0] fb, input int c_first,
                       input int c_last, input int full_until, input int n_done);
    int dcnt = 0;
    for (int c = c_first; c <= c_last; c++) begin
      @(negedge clk);
      chk({name, "_tx"}, tx, fb[(c / 24) * 6 + (c % 24) / 4]);
      chk({name, "_busy"}, busy, 1);
      chk({name, "_ready"}, in_ready, (c <= full_until) ? 0 : 1);
      if (done) dcnt++;
    end
    @(negedge clk);
    chk({name, "_idle_tx"}, tx, 1);
    chk({name, "_idle_busy"}, busy, 0);
    chk({name, "_done_count"}, dcnt, n_done);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", busy, 0);
  endtask

  typedef struct {
    logic [W-1:0] code;
    logic [5:0]   bits;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int w;
    int f0;
    logic [5:0] f6;
    vecs[0] = '{3'b101, 6'b101010};
    vecs[1] = '{3'b111, 6'b111110};
    vecs[2] = '{3'b000, 6'b100000};
    vecs[3] = '{3'b010, 6'b110100};
    vecs[4] = '{3'b100, 6'b111000};
    vecs[5] = '{3'b110, 6'b101100};

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_tx1", tx1, 1);
    chk("rst_ready1", r1, 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_tx", tx, 1);
    chk("post_rst_busy", busy, 0);

    // Single frames, one per table entry
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].code, w);
      @(negedge clk);
      chk("lat_ready", in_ready, 0);
      chk("lat_tx", tx, 1);
      watch("vec", {6'b0, vecs[i].bits}, 0, 23, -1, 1);
    end

    // Back-to-back: 001 then 110 with in_valid held
    send(3'b001, w);
    send(3'b110, w);
    chk("b2b_wait", w, 1);
    watch("b2b", {6'b101100, 6'b110010}, 1, 47, 23, 2);

    // in_valid held while the holding register is full: taken exactly once
    f0 = rx_frames;
    send(3'b111, w);
    send(3'b000, w);
    send(3'b010, w);
    chk("hold_wait", w, 23);
    wait_idle();
    repeat (30) @(negedge clk);
    chk("hold_frames", rx_frames - f0, 3);
    chk("hold_q_empty", exp_q.size(), 0);
    chk("hold_quiet_busy", busy, 0);

    // Reset during DATA bit 1 of 011
    send(3'b011, w);
    @(negedge clk);
    repeat (10) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_tx", tx, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_tx", tx, 1);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_ready", in_ready, 1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      chk("post_rst_quiet", {tx, busy}, 2'b10);
    end
    send(3'b101, w);
    @(negedge clk);
    watch("recover", {6'b0, 6'b101010}, 0, 23, -1, 1);

    // DIV=1: 100 -> 0,0,0,1,1,1
    f6 = 6'b111000;
    @(negedge clk);
    v1 = 1'b1;
    c1 = 3'b100;
    chk("div1_ready", r1, 1);
    @(posedge clk);
    #1 v1 = 1'b0;
    @(negedge clk);
    chk("div1_lat_tx", tx1, 1);
    chk("div1_lat_ready", r1, 0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("div1_tx", tx1, f6[c]);
      chk("div1_done", d1, (c == 5) ? 1 : 0);
      chk("div1_busy", b1, 1);
    end
    @(negedge clk);
    chk("div1_idle_tx", tx1, 1);
    chk("div1_idle_busy", b1, 0);
    chk("div1_idle_done", d1, 0);

    chk("final_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
